// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in parallel-out receiver.
// Holds the default word width, the holding-register state type and the counter-width helper.
package sipo_pkg;

    localparam int SIPO_WIDTH_DEF = 16;

    typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_state_e;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register, bit counter and word realignment for the SIPO receiver.
// word/word_done are combinational and describe the word completing at the coming edge.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH_DEF,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] word,
    output logic             word_done,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // The LSB of a full shift register would be discarded on completion, so only
    // the upper WIDTH-1 bits are stored; the incoming bit supplies the MSB.
    logic [WIDTH-2:0] sr;

    assign word      = {serial_in, sr};
    assign word_done = bit_valid && !sync && (bit_cnt == LAST_BIT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (sync) begin
            if (bit_valid) begin
                sr      <= word[WIDTH-1:1];
                bit_cnt <= CNT_W'(1);
            end else begin
                bit_cnt <= '0;
            end
        end else if (bit_valid) begin
            sr      <= word[WIDTH-1:1];
            bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: rebuilds LSB-first words and presents them on a
// one-entry valid/ready holding register with a sticky overflow flag.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH_DEF,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] bit_cnt
);

    logic [WIDTH-1:0] word;
    logic             word_done;
    hold_state_e      state;

    sipo_shift_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .serial_in (serial_in),
        .bit_valid (bit_valid),
        .sync      (sync),
        .word      (word),
        .word_done (word_done),
        .bit_cnt   (bit_cnt)
    );

    assign out_valid = (state == HOLD_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HOLD_EMPTY;
            parallel_out <= '0;
            overflow     <= 1'b0;
        end else begin
            case (state)
                HOLD_EMPTY: begin
                    if (word_done) begin
                        parallel_out <= word;
                        state        <= HOLD_FULL;
                    end
                end
                HOLD_FULL: begin
                    if (out_ready) begin
                        // Accept and refill on the same edge keeps the register full.
                        if (word_done) parallel_out <= word;
                        else           state        <= HOLD_EMPTY;
                    end else if (word_done) begin
                        overflow <= 1'b1;
                    end
                end
                default: state <= HOLD_EMPTY;
            endcase
        end
    end

endmodule
